// File: rtl/fifo_serial_tx.sv
// Pops words from a show-ahead FIFO and sends each as an async serial frame:
// start bit, data LSB first, optional parity, stop bit(s); back-to-back frames when data is waiting.
module fifo_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic [15:0]      frames_sent
);

  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int BITW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BITW-1:0] DATA_LAST = BITW'(WIDTH - 1);
  localparam logic [BITW-1:0] STOP_LAST = BITW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [BITW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic [15:0]      frames_q, frames_d;
  logic             baud_end, last_stop, pop;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    frames_d  = frames_q;
    baud_end  = (baud_q == BAUD_LAST);
    last_stop = (state_q == ST_STOP) && baud_end && (bit_q == STOP_LAST);
    pop       = en && !fifo_empty && ((state_q == ST_IDLE) || last_stop);

    if (state_q != ST_IDLE) baud_d = baud_end ? '0 : baud_q + 1'b1;

    case (state_q)
      ST_START: if (baud_end) begin
        state_d = ST_DATA;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      ST_DATA: if (baud_end) begin
        if (bit_q == DATA_LAST) begin
          bit_d = '0;
          if (PARITY != 0) begin
            state_d = ST_PAR;
            tx_d    = par_q;
          end else begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          tx_d    = shift_d[0];
        end
      end
      ST_PAR: if (baud_end) begin
        state_d = ST_STOP;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
      ST_STOP: if (baud_end && !last_stop) bit_d = bit_q + 1'b1;
      default: tx_d = 1'b1;
    endcase

    if (last_stop) begin
      frames_d = frames_q + 16'd1;
      state_d  = ST_IDLE;
      bit_d    = '0;
      busy_d   = 1'b0;
      tx_d     = 1'b1;
    end

    // A pop on the last stop cycle overrides the return to idle: no gap between frames.
    if (pop) begin
      state_d = ST_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = fifo_dout;
      par_d   = (^fifo_dout) ^ (PARITY == 2);
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      frames_q <= frames_d;
    end
  end

  assign fifo_rd_en  = pop;
  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frames_sent = frames_q;

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Read-side consumer for the team's show-ahead synchronous FIFO (empty/dout/rd_en interface). It pops words one at a time and transmits each as an asynchronous serial frame on a single line: start bit, data LSB first, optional parity, then stop bit(s). It sits between a FIFO instance and an off-chip UART-style pin, and is the transmit counterpart to the write-side producers that fill the FIFO.

Parameters:
WIDTH, 8, data bits per frame; must equal the attached FIFO WIDTH.
CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2.
PARITY, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  transmit enable; sampled only at frame boundaries.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  WIDTH  FIFO head word, valid whenever fifo_empty=0 (show-ahead).
fifo_rd_en  output  1  pop strobe to FIFO, combinational, one cycle per frame.
tx  output  1  serial line, registered, idle high.
busy  output  1  high from the cycle after a pop through the last stop-bit cycle.
frames_sent  output  16  count of completed frames, wraps 0xFFFF -> 0.

Behaviour:
- Reset (async): state IDLE; tx=1, busy=0, frames_sent=0, fifo_rd_en=0; bit and baud counters=0. Reset mid-frame aborts the frame. The popped word is lost; no partial frame resumes.
- States: IDLE, START, DATA, PARITY, STOP.
- Pop condition: pop = en & !fifo_empty & (state==IDLE | last cycle of STOP). fifo_rd_en = pop, asserted for exactly one cycle. In the pop cycle, fifo_dout is latched into the shift register and parity is computed.
- Pop cycle T: tx drops to 0 at T+1. State START lasts CLKS_PER_BIT cycles.
- DATA: WIDTH bits, LSB first. Each bit is held CLKS_PER_BIT cycles. The shift register shifts right at each bit boundary.
- PARITY state: entered only if PARITY != 0. Even: tx = XOR of data bits. Odd: tx = inverted XOR.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- Frame length: CLKS_PER_BIT*(1+WIDTH+(PARITY!=0)+STOP_BITS) cycles.
- End of frame: frames_sent increments on the last STOP cycle.
  - If the pop condition holds in that cycle, the next frame starts with no idle gap; busy stays high.
  - Otherwise go to IDLE; busy=0 and tx=1 from the next cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets at each bit boundary. Bit counter width is clog2(WIDTH+1).
- en: deasserting mid-frame does not truncate the frame. It only blocks the next pop. fifo_rd_en is never asserted while en=0.
- FIFO going non-empty mid-frame: no pop occurs until the frame boundary.
- fifo_rd_en is never asserted while fifo_empty=1, so the FIFO never underflows.

Test Plan:
- Reset state: CLKS_PER_BIT=4, 8N1. Hold rst -> tx=1, busy=0, frames_sent=0, fifo_rd_en=0. Release with FIFO empty, run 100 cycles -> no change.
- Single frame: push 0xA5, en=1.
  - Required: one-cycle fifo_rd_en pulse.
  - tx sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1.
  - 40 cycles from the first tx=0 to the return to idle; frames_sent=1; busy falls after the stop bit.
- Back-to-back frames: push 0x00, 0xFF, 0x3C. Required:
  - 3 pops, exactly 40 cycles apart.
  - No idle-high gap beyond the stop bits.
  - frames_sent=3; the FIFO reads empty afterwards.
- Parity variants:
  - PARITY=1, send 0x07 -> parity bit 1. Send 0x03 -> parity bit 0.
  - PARITY=2 inverts both.
  - STOP_BITS=2 -> stop phase lasts 8 cycles; frame = 48 cycles with parity.
- en gating: preload 2 words, drop en midway through frame 1. Required:
  - Frame 1 completes intact; no second pop.
  - Re-assert en -> frame 2 starts with its pop in the same cycle.
- Reset mid-frame: assert rst during DATA bit 3 -> tx=1 and busy=0 immediately (async). After release, the next FIFO word transmits correctly.
- Counter wrap: force 65536 frames (or preload frames_sent via a bench shortcut) -> frames_sent wraps to 0.
